// File: rtl/boss_projectile_engine.sv
// boss_projectile_engine: captures bossShoot commands, advances up to five live projectiles per
// frame step, clears them at the floor or right edge, and pulses playerHit on overlap with the player.
// Ports: clk_master/rst_n (async active-low), pulse_frameStep, bossShoot/attackType,
//   proj1..5 X/Y + projW/projH command slots, player box in; live slot boxes, objActive,
//   beamOn and playerHit out.
// Optional feature: define PLAYER_IFRAME_EN for post-hit invulnerability frames.
module boss_projectile_engine #(
  parameter int PROJ_DY     = 4,
  parameter int DIAG_DX     = 3,
  parameter int FLOOR_Y     = 479,
  parameter int RIGHT_X     = 783,
  parameter int BEAM_FRAMES = 60
) (
  input  logic       clk_master,
  input  logic       rst_n,
  input  logic       pulse_frameStep,
  input  logic       bossShoot,
  input  logic [1:0] attackType,
  input  logic [9:0] proj1X, proj2X, proj3X, proj4X, proj5X,
  input  logic [8:0] proj1Y, proj2Y, proj3Y, proj4Y, proj5Y,
  input  logic [9:0] projW,
  input  logic [8:0] projH,
  input  logic [9:0] playerX,
  input  logic [8:0] playerY,
  input  logic [9:0] playerW,
  input  logic [8:0] playerH,
  output logic [9:0] objX1, objX2, objX3, objX4, objX5,
  output logic [8:0] objY1, objY2, objY3, objY4, objY5,
  output logic [9:0] objW,
  output logic [8:0] objH,
  output logic [4:0] objActive,
  output logic       beamOn,
  output logic       playerHit
);
  typedef enum logic {IDLE, LIVE} state_t;
  state_t state_q, state_d;
  logic [4:0][9:0] x_q, x_d, cx;
  logic [4:0][8:0] y_q, y_d, cy;
  logic [4:0][11:0] nx, ny;
  logic [4:0] act_q, act_d, lost, ovl;
  logic [9:0] w_q, w_d;
  logic [8:0] h_q, h_d;
  logic [1:0] typ_q, typ_d;
  logic [7:0] beam_q, beam_d;
  logic beam_on_q, beam_on_d, done_q, done_d, chk_q, hit_q, hit_d;
  logic load, move, iframe_ok, is_beam, is_diag;
  assign cx = {proj5X, proj4X, proj3X, proj2X, proj1X};
  assign cy = {proj5Y, proj4Y, proj3Y, proj2Y, proj1Y};
  assign load = bossShoot && attackType != 2'b11;
  assign move = pulse_frameStep && state_q == LIVE;
  assign is_beam = typ_q == 2'b01;
  assign is_diag = typ_q == 2'b10;
  // Per-slot candidate move and bounds test, widened so nothing wraps.
  for (genvar i = 0; i < 5; i++) begin : g_slot
    assign nx[i] = (is_diag && i == 0) ? 12'(x_q[i]) - 12'(DIAG_DX) :
                   (is_diag && i == 1) ? 12'(x_q[i]) + 12'(DIAG_DX) : 12'(x_q[i]);
    assign ny[i] = 12'(y_q[i]) + 12'(PROJ_DY);
    assign lost[i] = (is_diag && i == 0 && 12'(x_q[i]) < 12'(DIAG_DX)) ||
                     ny[i] + 12'(h_q) > 12'(FLOOR_Y) || nx[i] + 12'(w_q) > 12'(RIGHT_X);
    assign ovl[i] = act_q[i] &&
                    11'(x_q[i]) < 11'(playerX) + 11'(playerW) && 11'(playerX) < 11'(x_q[i]) + 11'(w_q) &&
                    11'(y_q[i]) < 11'(playerY) + 11'(playerH) && 11'(playerY) < 11'(y_q[i]) + 11'(h_q);
  end
`ifdef PLAYER_IFRAME_EN
  localparam int IFRAMES = 30;
  logic [7:0] ifr_q, ifr_d;
  assign iframe_ok = ifr_q == 8'd0;
  assign ifr_d = hit_d ? 8'(IFRAMES) : (pulse_frameStep && !iframe_ok) ? ifr_q - 8'd1 : ifr_q;
  always_ff @(posedge clk_master or negedge rst_n)
    if (!rst_n) ifr_q <= '0;
    else ifr_q <= ifr_d;
`else
  assign iframe_ok = 1'b1;
`endif
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    act_d = act_q;
    w_d = w_q;
    h_d = h_q;
    typ_d = typ_q;
    beam_d = beam_q;
    beam_on_d = beam_on_q;
    done_d = done_q;
    hit_d = 1'b0;
    if (load) begin
      for (int i = 0; i < 5; i++) begin
        x_d[i] = cx[i];
        y_d[i] = cy[i];
        act_d[i] = cx[i] != 10'd0;
      end
      w_d = projW;
      h_d = projH;
      typ_d = attackType;
      beam_d = attackType == 2'b01 ? 8'(BEAM_FRAMES) : 8'd0;
      beam_on_d = attackType == 2'b01 && act_d != 5'd0;
      done_d = 1'b0;
    end else begin
      if (move && is_beam) begin
        beam_d = beam_q - 8'd1;
        if (beam_q == 8'd1) begin
          act_d = '0;
          x_d = '0;
          y_d = '0;
          beam_on_d = 1'b0;
        end
      end else if (move) begin
        for (int i = 0; i < 5; i++)
          if (act_q[i]) begin
            act_d[i] = !lost[i];
            x_d[i] = lost[i] ? 10'd0 : nx[i][9:0];
            y_d[i] = lost[i] ? 9'd0 : ny[i][8:0];
          end
      end
      // Beam slots survive a hit but may only score once per load.
      if (chk_q && iframe_ok && ovl != 5'd0 && !(is_beam && done_q)) begin
        hit_d = 1'b1;
        done_d = done_q | is_beam;
        if (!is_beam)
          for (int i = 0; i < 5; i++)
            if (ovl[i]) begin
              act_d[i] = 1'b0;
              x_d[i] = 10'd0;
              y_d[i] = 9'd0;
            end
      end
    end
    state_d = act_d != 5'd0 ? LIVE : IDLE;
  end
  always_ff @(posedge clk_master or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      act_q <= '0;
      w_q <= '0;
      h_q <= '0;
      typ_q <= '0;
      beam_q <= '0;
      beam_on_q <= 1'b0;
      done_q <= 1'b0;
      chk_q <= 1'b0;
      hit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      act_q <= act_d;
      w_q <= w_d;
      h_q <= h_d;
      typ_q <= typ_d;
      beam_q <= beam_d;
      beam_on_q <= beam_on_d;
      done_q <= done_d;
      chk_q <= pulse_frameStep;
      hit_q <= hit_d;
    end
  assign {objX5, objX4, objX3, objX2, objX1} = x_q;
  assign {objY5, objY4, objY3, objY2, objY1} = y_q;
  assign objW = w_q;
  assign objH = h_q;
  assign objActive = act_q;
  assign beamOn = beam_on_q;
  assign playerHit = hit_q;
endmodule

// File: tb/tb_boss_projectile_engine.sv
// tb_boss_projectile_engine: directed-vector self-checking bench for boss_projectile_engine.
module tb_boss_projectile_engine;
  logic clk_master = 1'b0, rst_n = 1'b0, pulse_frameStep = 1'b0, bossShoot = 1'b0;
  logic [1:0] attackType = 2'b00;
  logic [9:0] px [5];
  logic [8:0] py [5];
  logic [9:0] projW = '0, playerX = '0, playerW = '0;
  logic [8:0] projH = '0, playerY = '0, playerH = '0;
  logic [9:0] objX1, objX2, objX3, objX4, objX5, objW;
  logic [8:0] objY1, objY2, objY3, objY4, objY5, objH;
  logic [4:0] objActive;
  logic beamOn, playerHit;
  int n_chk = 0, n_fail = 0, hit_cnt = 0, base = 0;
  boss_projectile_engine dut (
    .clk_master(clk_master), .rst_n(rst_n), .pulse_frameStep(pulse_frameStep),
    .bossShoot(bossShoot), .attackType(attackType),
    .proj1X(px[0]), .proj2X(px[1]), .proj3X(px[2]), .proj4X(px[3]), .proj5X(px[4]),
    .proj1Y(py[0]), .proj2Y(py[1]), .proj3Y(py[2]), .proj4Y(py[3]), .proj5Y(py[4]),
    .projW(projW), .projH(projH), .playerX(playerX), .playerY(playerY),
    .playerW(playerW), .playerH(playerH),
    .objX1(objX1), .objX2(objX2), .objX3(objX3), .objX4(objX4), .objX5(objX5),
    .objY1(objY1), .objY2(objY2), .objY3(objY3), .objY4(objY4), .objY5(objY5),
    .objW(objW), .objH(objH), .objActive(objActive), .beamOn(beamOn), .playerHit(playerHit)
  );
  always #5 clk_master = ~clk_master;
  always @(negedge clk_master) if (playerHit) hit_cnt <= hit_cnt + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic set_cmd(input logic [1:0] t, input int x0, x1, x2, x3, x4, input int y, w, h);
    attackType = t;
    px[0] = 10'(x0); px[1] = 10'(x1); px[2] = 10'(x2); px[3] = 10'(x3); px[4] = 10'(x4);
    for (int i = 0; i < 5; i++) py[i] = 9'(y);
    projW = 10'(w);
    projH = 9'(h);
  endtask
  task automatic load(input logic [1:0] t, input int x0, x1, x2, x3, x4, input int y, w, h);
    @(negedge clk_master);
    set_cmd(t, x0, x1, x2, x3, x4, y, w, h);
    bossShoot = 1'b1;
    @(negedge clk_master);
    bossShoot = 1'b0;
  endtask
  task automatic steps(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk_master);
      pulse_frameStep = 1'b1;
      @(negedge clk_master);
      pulse_frameStep = 1'b0;
      repeat (2) @(negedge clk_master);
    end
  endtask
  task automatic set_player(input int x, y, w, h);
    playerX = 10'(x); playerY = 9'(y); playerW = 10'(w); playerH = 9'(h);
  endtask
  initial begin
    for (int i = 0; i < 5; i++) begin px[i] = '0; py[i] = '0; end
    repeat (2) @(negedge clk_master);
    chk("rst_act", objActive, 0);
    chk("rst_beam", beamOn, 0);
    chk("rst_hit", playerHit, 0);
    chk("rst_w", objW, 0);
    rst_n = 1'b1;
    set_player(0, 0, 0, 0);
    load(2'b00, 259, 359, 459, 559, 659, 231, 10, 15);
    chk("proj_act", objActive, 5'b11111);
    chk("proj_x1", objX1, 259);
    chk("proj_y5", objY5, 231);
    chk("proj_w", objW, 10);
    chk("proj_h", objH, 15);
    steps(1);
    chk("proj_y1_1", objY1, 235);
    chk("proj_x5_1", objX5, 659);
    steps(57);
    chk("proj_y1_58", objY1, 463);
    chk("proj_act_58", objActive, 5'b11111);
    steps(1);
    chk("proj_act_59", objActive, 5'b00000);
    chk("proj_x1_59", objX1, 0);
    load(2'b10, 244, 684, 0, 0, 0, 231, 20, 20);
    chk("diag_act", objActive, 5'b00011);
    steps(10);
    chk("diag_x1_10", objX1, 214);
    chk("diag_x2_10", objX2, 714);
    chk("diag_y1_10", objY1, 271);
    steps(16);
    chk("diag_act_26", objActive, 5'b00011);
    chk("diag_x2_26", objX2, 762);
    steps(1);
    chk("diag_act_27", objActive, 5'b00001);
    chk("diag_x2_27", objX2, 0);
    chk("diag_x1_27", objX1, 163);
    @(negedge clk_master);
    set_cmd(2'b00, 259, 359, 459, 559, 659, 231, 10, 15);
    bossShoot = 1'b1;
    pulse_frameStep = 1'b1;
    @(negedge clk_master);
    bossShoot = 1'b0;
    pulse_frameStep = 1'b0;
    chk("same_y1", objY1, 231);
    chk("same_act", objActive, 5'b11111);
    set_player(250, 400, 20, 20);
    base = hit_cnt;
    load(2'b01, 234, 634, 0, 0, 0, 150, 60, 280);
    chk("beam_on", beamOn, 1);
    chk("beam_act", objActive, 5'b00011);
    steps(59);
    chk("beam_on_59", beamOn, 1);
    chk("beam_y1_59", objY1, 150);
    chk("beam_hits_59", hit_cnt - base, 1);
    steps(1);
    chk("beam_on_60", beamOn, 0);
    chk("beam_act_60", objActive, 0);
    chk("beam_hits_60", hit_cnt - base, 1);
    set_player(359, 300, 10, 10);
    load(2'b00, 259, 359, 459, 559, 659, 231, 10, 15);
    base = hit_cnt;
    steps(13);
    chk("hit_act_13", objActive, 5'b11111);
    chk("hit_cnt_13", hit_cnt - base, 0);
    steps(1);
    chk("hit_act_14", objActive, 5'b11101);
    chk("hit_cnt_14", hit_cnt - base, 1);
    chk("hit_y2_14", objY2, 0);
    chk("hit_y1_14", objY1, 287);
    steps(6);
    chk("hit_cnt_20", hit_cnt - base, 1);
    load(2'b11, 100, 100, 100, 100, 100, 10, 5, 5);
    chk("ign_act", objActive, 5'b11101);
    chk("ign_x1", objX1, 259);
    set_player(0, 0, 0, 0);
    load(2'b01, 234, 634, 0, 0, 0, 150, 60, 280);
    steps(1);
    chk("mid_beam_on", beamOn, 1);
    @(negedge clk_master);
    set_player(250, 400, 20, 20);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_act", objActive, 0);
    chk("mid_rst_beam", beamOn, 0);
    chk("mid_rst_hit", playerHit, 0);
    @(negedge clk_master);
    rst_n = 1'b1;
    base = hit_cnt;
    steps(3);
    chk("post_rst_hits", hit_cnt - base, 0);
    chk("post_rst_act", objActive, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
